// File: rtl/onchip_memory_stream_loader_pkg.sv
// Shared constants, FSM state encoding and helpers for the on-chip RAM stream loader.
package onchip_memory_stream_loader_pkg;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = DATA_W / 8;
   localparam int unsigned DEPTH  = 1 << ADDR_W;
   localparam int unsigned CNT_W  = ADDR_W + 1;

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StVerify,
      StVdrain,
      StCheck,
      StDone
   } state_e;

   // Word counts above the RAM size collapse to one full pass over the RAM.
   function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] count);
      return (count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : count;
   endfunction

endpackage

// File: rtl/onchip_memory_stream_loader_if.sv
// Stream input and Avalon RAM slave pins, bundled for the loader.
interface onchip_memory_stream_loader_if;
   import onchip_memory_stream_loader_pkg::*;

   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_ready;
   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic [DATA_W-1:0] mem_writedata;
   logic              mem_clken;
   logic [DATA_W-1:0] mem_readdata;

   // Loader side: consumes the stream and drives the RAM.
   modport master (
      input  s_valid, s_data, mem_readdata,
      output s_ready, mem_address, mem_byteenable, mem_chipselect, mem_write,
             mem_writedata, mem_clken
   );

   // Environment side: stream source and RAM.
   modport slave (
      output s_valid, s_data, mem_readdata,
      input  s_ready, mem_address, mem_byteenable, mem_chipselect, mem_write,
             mem_writedata, mem_clken
   );

endinterface

// File: rtl/onchip_memory_stream_loader.sv
// Loads a valid/ready word stream into consecutive RAM words, then optionally reads the
// range back and compares additive checksums.
module onchip_memory_stream_loader
   import onchip_memory_stream_loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [CNT_W-1:0]      word_count,
   input  logic                  verify_en,
   onchip_memory_stream_loader_if.master bus,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              verify_q;
   logic [CNT_W-1:0]  idx_q;
   logic [CNT_W-1:0]  ridx_q;
   logic [DATA_W-1:0] wsum_q;
   logic [DATA_W-1:0] rsum_q;
   logic              rd_valid_q;
   logic              error_q;

   logic              accept;
   logic              rd_issue;
   logic              cmd_take;
   logic              s_ready;
   logic              cs;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;

   assign cmd_take = (state_q == StIdle) && start;

   // Next-state decode and all RAM/stream/status outputs, combinational from state.
   always_comb begin
      state_d  = state_q;
      s_ready  = 1'b0;
      cs       = 1'b0;
      wr       = 1'b0;
      addr     = '0;
      wdata    = '0;
      done     = 1'b0;
      accept   = 1'b0;
      rd_issue = 1'b0;
      busy     = (state_q != StIdle) && (state_q != StDone);
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = (clamp_count(word_count) == '0) ? StDone : StWrite;
            end
         end
         StWrite: begin
            s_ready = 1'b1;
            if (bus.s_valid) begin
               accept = 1'b1;
               cs     = 1'b1;
               wr     = 1'b1;
               // ADDR_W-wide sum drops the carry, giving the modulo-DEPTH wrap.
               addr   = base_q + idx_q[ADDR_W-1:0];
               wdata  = bus.s_data;
               if (idx_q + CNT_W'(1) == cnt_q) begin
                  state_d = verify_q ? StVerify : StDone;
               end
            end
         end
         StVerify: begin
            cs       = 1'b1;
            rd_issue = 1'b1;
            addr     = base_q + ridx_q[ADDR_W-1:0];
            if (ridx_q + CNT_W'(1) == cnt_q) begin
               state_d = StVdrain;
            end
         end
         StVdrain: state_d = StCheck;
         StCheck:  state_d = StDone;
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default:  state_d = StIdle;
      endcase
   end

   assign bus.s_ready        = s_ready;
   assign bus.mem_chipselect = cs;
   assign bus.mem_write      = wr;
   assign bus.mem_address    = addr;
   assign bus.mem_writedata  = wdata;
   assign bus.mem_byteenable = {BE_W{cs}};
   assign bus.mem_clken      = ~reset;
   assign error              = error_q;

   // State register, command latch, counters, checksums and read-valid pipeline.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         base_q     <= '0;
         cnt_q      <= '0;
         verify_q   <= 1'b0;
         idx_q      <= '0;
         ridx_q     <= '0;
         wsum_q     <= '0;
         rsum_q     <= '0;
         rd_valid_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_valid_q <= rd_issue;
         if (cmd_take) begin
            base_q   <= base_addr;
            cnt_q    <= clamp_count(word_count);
            verify_q <= verify_en;
            idx_q    <= '0;
            ridx_q   <= '0;
            wsum_q   <= '0;
            rsum_q   <= '0;
            error_q  <= 1'b0;
         end else begin
            if (accept) begin
               idx_q  <= idx_q + CNT_W'(1);
               wsum_q <= wsum_q + bus.s_data;
            end
            if (rd_issue) begin
               ridx_q <= ridx_q + CNT_W'(1);
            end
            // Read data lags its address by one cycle; the valid bit marks it.
            if (rd_valid_q) begin
               rsum_q <= rsum_q + bus.mem_readdata;
            end
            if (state_q == StCheck) begin
               error_q <= (rsum_q != wsum_q);
            end
         end
      end
   end

endmodule
